// File: rtl/unsigned_mac_acc.sv
// Accumulates N_TERMS unsigned 8-bit products into an ACC_W-bit sum behind a valid/ready handshake.
// Define SATURATE_EN to clamp on carry out; otherwise the sum wraps and only the sticky overflow flag records it.
module unsigned_mac_acc #(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             prod_valid,
  input  logic [7:0]       prod_in,
  output logic             prod_ready,
  output logic             busy,
  output logic [ACC_W-1:0] acc_out,
  output logic             done,
  output logic             overflow
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  localparam logic [7:0] LAST = 8'(N_TERMS);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   sum;
  logic             carry;

  // One extra bit so the carry out of the accumulator is visible.
  assign sum   = {1'b0, acc_q} + {{(ACC_W-7){1'b0}}, prod_in};
  assign carry = sum[ACC_W];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACCUM;
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      S_ACCUM: begin
        if (prod_valid) begin
          count_d = count_q + 8'd1;
          if (carry) ovf_d = 1'b1;
`ifdef SATURATE_EN
          // Once clamped, any further nonzero product carries again, so the clamp holds.
          acc_d = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
          acc_d = sum[ACC_W-1:0];
`endif
          if (count_d == LAST) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake outputs decode the state register only; nothing from prod_valid reaches them.
  assign prod_ready = (state_q == S_ACCUM);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign acc_out    = acc_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_unsigned_mac_acc.sv
// Bench for unsigned_mac_acc: a default instance and a narrow instance (ACC_W=10, N_TERMS=8) for overflow,
// checked against a plain-arithmetic model of the true sum.
module tb_unsigned_mac_acc;
  localparam int A_N = 4, A_W = 12, B_N = 8, B_W = 10;

  logic clk = 1'b0;
  logic rst;

  logic           a_start, a_valid, a_ready, a_busy, a_done, a_ovf;
  logic [7:0]     a_prod;
  logic [A_W-1:0] a_acc;
  logic           b_start, b_valid, b_ready, b_busy, b_done, b_ovf;
  logic [7:0]     b_prod;
  logic [B_W-1:0] b_acc;

  logic [31:0] o_acc;
  logic        o_rdy, o_busy, o_done, o_ovf;
  logic [7:0]  prods [0:255];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  unsigned_mac_acc #(.N_TERMS(A_N), .ACC_W(A_W)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .prod_valid(a_valid), .prod_in(a_prod),
    .prod_ready(a_ready), .busy(a_busy), .acc_out(a_acc), .done(a_done), .overflow(a_ovf));

  unsigned_mac_acc #(.N_TERMS(B_N), .ACC_W(B_W)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .prod_valid(b_valid), .prod_in(b_prod),
    .prod_ready(b_ready), .busy(b_busy), .acc_out(b_acc), .done(b_done), .overflow(b_ovf));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: the true sum, then clamp or wrap to the accumulator width.
  function automatic logic [31:0] exp_acc(input longint s, input int w);
    longint mx = (longint'(1) << w) - 1;
`ifdef SATURATE_EN
    return (s > mx) ? 32'(mx) : 32'(s);
`else
    return 32'(s & mx);
`endif
  endfunction

  function automatic logic [31:0] exp_ovf(input longint s, input int w);
    return (s > ((longint'(1) << w) - 1)) ? 32'd1 : 32'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit b, input logic s, input logic v, input logic [7:0] p);
    if (b) begin b_start = s; b_valid = v; b_prod = p; end
    else   begin a_start = s; a_valid = v; a_prod = p; end
  endtask

  task automatic sample(input bit b);
    if (b) begin o_acc = 32'(b_acc); o_rdy = b_ready; o_busy = b_busy; o_done = b_done; o_ovf = b_ovf; end
    else   begin o_acc = 32'(a_acc); o_rdy = a_ready; o_busy = a_busy; o_done = a_done; o_ovf = a_ovf; end
  endtask

  // One full operation using prods[0..n-1]; mode 0 no bubbles, 1 two bubbles between terms, 2 random bubbles.
  task automatic run_op(input bit b, input int n, input int mode, input bit noise);
    int     w   = b ? B_W : A_W;
    longint sum = 0;
    int     gap;
    drive(b, 1'b1, 1'b0, 8'd0);
    tick();
    sample(b);
    chk("start_acc", o_acc, 32'd0);
    chk("start_ovf", 32'(o_ovf), 32'd0);
    chk("start_rdy", 32'(o_rdy), 32'd1);
    chk("start_busy", 32'(o_busy), 32'd1);
    for (int k = 0; k < n; k++) begin
      gap = (k == 0) ? 0 : (mode == 1) ? 2 : (mode == 2) ? int'($urandom_range(0, 3)) : 0;
      for (int g = 0; g < gap; g++) begin
        drive(b, noise ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0, 8'($urandom));
        tick();
        sample(b);
        chk("bubble_acc", o_acc, exp_acc(sum, w));
        chk("bubble_done", 32'(o_done), 32'd0);
        chk("bubble_rdy", 32'(o_rdy), 32'd1);
      end
      drive(b, noise ? 1'($urandom_range(0, 1)) : 1'b0, 1'b1, prods[k]);
      tick();
      sum += longint'(prods[k]);
      sample(b);
      chk("acc", o_acc, exp_acc(sum, w));
      chk("ovf", 32'(o_ovf), exp_ovf(sum, w));
      chk("done", 32'(o_done), (k == n - 1) ? 32'd1 : 32'd0);
      if (k < n - 1) chk("rdy", 32'(o_rdy), 32'd1);
    end
    chk("done_rdy", 32'(o_rdy), 32'd0);
    chk("done_busy", 32'(o_busy), 32'd1);
    drive(b, noise, noise, 8'hFF);
    tick();
    sample(b);
    chk("idle_done", 32'(o_done), 32'd0);
    chk("idle_busy", 32'(o_busy), 32'd0);
    chk("idle_rdy", 32'(o_rdy), 32'd0);
    chk("idle_acc", o_acc, exp_acc(sum, w));
    chk("idle_ovf", 32'(o_ovf), exp_ovf(sum, w));
    drive(b, 1'b0, 1'b0, 8'd0);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    drive(1'b1, 1'b0, 1'b0, 8'd0);
    tick();
    tick();
    for (int b = 0; b < 2; b++) begin
      sample(b[0]);
      chk("rst_acc", o_acc, 32'd0);
      chk("rst_rdy", 32'(o_rdy), 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_done", 32'(o_done), 32'd0);
      chk("rst_ovf", 32'(o_ovf), 32'd0);
    end
    rst = 1'b0;
    tick();

    // Basic sum: 4 x 225 back-to-back.
    for (int k = 0; k < A_N; k++) prods[k] = 8'd225;
    run_op(1'b0, A_N, 0, 1'b0);

    // Products offered in IDLE are dropped.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 8'd255);
      tick();
      sample(1'b0);
      chk("idle_drop_acc", o_acc, 32'd900);
      chk("idle_drop_rdy", 32'(o_rdy), 32'd0);
    end
    drive(1'b0, 1'b0, 1'b0, 8'd0);

    // Two bubbles between each term, with start noise.
    prods[0] = 8'd10; prods[1] = 8'd20; prods[2] = 8'd30; prods[3] = 8'd40;
    run_op(1'b0, A_N, 1, 1'b1);

    // Overflow on the narrow instance: 8 x 225 = 1800.
    for (int k = 0; k < B_N; k++) prods[k] = 8'd225;
    run_op(1'b1, B_N, 0, 1'b0);

    // Reset mid-operation, asserted while a product is offered.
    drive(1'b0, 1'b1, 1'b0, 8'd0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 8'd100);
    tick();
    tick();
    sample(1'b0);
    chk("mid_acc", o_acc, 32'd200);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sample(1'b0);
    chk("mid_rst_acc", o_acc, 32'd0);
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    chk("mid_rst_rdy", 32'(o_rdy), 32'd0);
    chk("mid_rst_done", 32'(o_done), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      sample(1'b0);
      chk("mid_no_done", 32'(o_done), 32'd0);
      chk("mid_no_busy", 32'(o_busy), 32'd0);
    end
    for (int k = 0; k < A_N; k++) prods[k] = 8'd1;
    run_op(1'b0, A_N, 0, 1'b0);

    // Randomized operations with random bubbles and ignored start pulses.
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < A_N; k++) prods[k] = 8'($urandom_range(0, 255));
      run_op(1'b0, A_N, 2, 1'b1);
    end
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < B_N; k++) prods[k] = 8'($urandom_range(0, 255));
      run_op(1'b1, B_N, 2, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
